// File: rtl/deser_pkg.sv
// Shared types and constants for the deser_reg serial-to-parallel receiver.
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic DIR_LSB_FIRST = 1'b1;
  localparam logic DIR_MSB_FIRST = 1'b0;

endpackage

// File: rtl/deser_shift_cell.sv
// One bit of the receive shift register: a flop fed from either neighbour,
// with a synchronous clear used when a word completes.
module deser_shift_cell (
  input  logic clock,
  input  logic resetn,
  input  logic shift_en,
  input  logic clear,
  input  logic take_left,
  input  logic left,
  input  logic right,
  output logic q
);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q <= 1'b0;
    end else if (clear) begin
      q <= 1'b0;
    end else if (shift_en) begin
      q <= take_left ? left : right;
    end
  end

endmodule

// File: rtl/deser_reg.sv
// Serial-to-parallel receiver with a double-buffered, valid/ready output word
// and a sticky overrun flag. Define DESER_PARITY_EN to add an even-parity bit.
//   state  | meaning
//   IDLE   | no bits collected, next valid bit starts a word
//   SHIFT  | 1..WIDTH-1 data bits collected
//   PARITY | all data bits collected, waiting for the parity bit
module deser_reg
  import deser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             SerialIn,
  input  logic             SerialValid,
  input  logic             ShiftRight,
  input  logic             WordReady,
  input  logic             ClearOvr,
  output logic [WIDTH-1:0] Data_OUT,
  output logic             WordValid,
  output logic             Overrun,
  output logic [CNT_W-1:0] BitCount
`ifdef DESER_PARITY_EN
  ,
  output logic             ParityErr
`endif
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dir_q, dir_nxt, dir_use;
  logic             shift_en, clear_sr, complete, commit, drop;
  logic [WIDTH-1:0] sr, word;

  // First bit of a word uses the live ShiftRight; later bits use the latched one.
  assign dir_use = (state == IDLE) ? ShiftRight : dir_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      BitCount <= '0;
      dir_q    <= DIR_MSB_FIRST;
    end else begin
      state    <= state_nxt;
      BitCount <= cnt_nxt;
      dir_q    <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = BitCount;
    dir_nxt   = dir_q;
    shift_en  = 1'b0;
    clear_sr  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (SerialValid) begin
          dir_nxt   = ShiftRight;
          shift_en  = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (SerialValid) begin
          shift_en = 1'b1;
          if (BitCount == CNT_W'(WIDTH - 1)) begin
`ifdef DESER_PARITY_EN
            cnt_nxt   = CNT_W'(WIDTH);
            state_nxt = PARITY;
`else
            complete  = 1'b1;
            clear_sr  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
`endif
          end else begin
            cnt_nxt = BitCount + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef DESER_PARITY_EN
        if (SerialValid) begin
          complete  = 1'b1;
          clear_sr  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge cells take SerialIn as their outside neighbour.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic left_nb, right_nb;
    if (i == WIDTH - 1) begin : g_msb
      assign left_nb = SerialIn;
    end else begin : g_mid_l
      assign left_nb = sr[i+1];
    end
    if (i == 0) begin : g_lsb
      assign right_nb = SerialIn;
    end else begin : g_mid_r
      assign right_nb = sr[i-1];
    end
    deser_shift_cell u_cell (
      .clock     (clock),
      .resetn    (resetn),
      .shift_en  (shift_en),
      .clear     (clear_sr),
      .take_left (dir_use == DIR_LSB_FIRST),
      .left      (left_nb),
      .right     (right_nb),
      .q         (sr[i])
    );
  end

`ifdef DESER_PARITY_EN
  assign word = sr;
`else
  // The completing bit is not yet in sr, so build the word as it would shift.
  assign word = (dir_use == DIR_LSB_FIRST) ? {SerialIn, sr[WIDTH-1:1]}
                                           : {sr[WIDTH-2:0], SerialIn};
`endif

  assign commit = complete && (!WordValid || WordReady);
  assign drop   = complete && WordValid && !WordReady;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      Data_OUT  <= '0;
      WordValid <= 1'b0;
      Overrun   <= 1'b0;
`ifdef DESER_PARITY_EN
      ParityErr <= 1'b0;
`endif
    end else begin
      if (commit) begin
        Data_OUT  <= word;
        WordValid <= 1'b1;
`ifdef DESER_PARITY_EN
        ParityErr <= (^word) ^ SerialIn;
`endif
      end else if (WordReady) begin
        WordValid <= 1'b0;
      end
      if (drop) begin
        Overrun <= 1'b1;
      end else if (ClearOvr) begin
        Overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deser_reg.sv
// Randomized and directed bench for deser_reg against a bit-queue reference model.
module tb_deser_reg;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          SerialIn = 1'b0, SerialValid = 1'b0, ShiftRight = 1'b0;
  logic          WordReady = 1'b0, ClearOvr = 1'b0;
  logic [W-1:0]  Data_OUT;
  logic          WordValid, Overrun;
  logic [CW-1:0] BitCount;
`ifdef DESER_PARITY_EN
  logic          ParityErr;
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  deser_reg #(.WIDTH(W)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .SerialIn    (SerialIn),
    .SerialValid (SerialValid),
    .ShiftRight  (ShiftRight),
    .WordReady   (WordReady),
    .ClearOvr    (ClearOvr),
    .Data_OUT    (Data_OUT),
    .WordValid   (WordValid),
    .Overrun     (Overrun),
    .BitCount    (BitCount)
`ifdef DESER_PARITY_EN
    ,
    .ParityErr   (ParityErr)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  bit           q_bits[$];
  bit           m_dir;
  logic [W-1:0] m_data;
  bit           m_valid, m_ovr, m_perr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_bits.delete();
    m_dir = 1'b0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  function automatic logic [W-1:0] assemble();
    logic [W-1:0] w = '0;
    for (int k = 0; k < W; k++) begin
      if (m_dir) w[k] = q_bits[k];
      else       w[W-1-k] = q_bits[k];
    end
    return w;
  endfunction

  task automatic model_step(input bit sv, input bit si, input bit sr, input bit rdy, input bit clr);
    bit           complete = 1'b0;
    bit           drop = 1'b0;
    bit           pe = 1'b0;
    logic [W-1:0] w = '0;
    if (sv) begin
      if (q_bits.size() == 0) m_dir = sr;
      if (PAR && q_bits.size() == W) begin
        w = assemble();
        pe = (^w) ^ si;
        complete = 1'b1;
        q_bits.delete();
      end else begin
        q_bits.push_back(si);
        if (!PAR && q_bits.size() == W) begin
          w = assemble();
          complete = 1'b1;
          q_bits.delete();
        end
      end
    end
    if (complete && (!m_valid || rdy)) begin
      m_data = w; m_valid = 1'b1; m_perr = pe;
    end else if (complete) begin
      drop = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_all();
    chk("Data_OUT", 32'(Data_OUT), 32'(m_data));
    chk("WordValid", 32'(WordValid), 32'(m_valid));
    chk("Overrun", 32'(Overrun), 32'(m_ovr));
    chk("BitCount", 32'(BitCount), 32'(q_bits.size()));
`ifdef DESER_PARITY_EN
    chk("ParityErr", 32'(ParityErr), 32'(m_perr));
`endif
  endtask

  task automatic apply(input bit sv, input bit si, input bit sr, input bit rdy, input bit clr);
    @(negedge clock);
    SerialValid = sv; SerialIn = si; ShiftRight = sr; WordReady = rdy; ClearOvr = clr;
    model_step(sv, si, sr, rdy, clr);
    @(posedge clock);
    #1;
    check_all();
  endtask

  // Sends one word (plus even parity when enabled); WordReady only on the final bit.
  task automatic send_word(input logic [W-1:0] w, input bit sr, input bit rdy_last);
    bit b;
    for (int k = 0; k < W; k++) begin
      b = sr ? w[k] : w[W-1-k];
      apply(1'b1, b, sr, (k == W - 1 && !PAR) ? rdy_last : 1'b0, 1'b0);
    end
    if (PAR) apply(1'b1, ^w, sr, rdy_last, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check_all();
    resetn = 1'b1;

    // LSB-first, consecutive bits 1,0,1,1
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); chk("t1_cnt1", 32'(BitCount), 1);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); chk("t1_cnt2", 32'(BitCount), 2);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); chk("t1_cnt3", 32'(BitCount), 3);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    if (PAR) apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_data", 32'(Data_OUT), 32'h0000_000d);
    chk("t1_valid", 32'(WordValid), 1);
    chk("t1_cnt0", 32'(BitCount), 0);

    // MSB-first with gaps; ShiftRight toggled mid-word; consume old word first
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); chk("t2_hold", 32'(BitCount), 1);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    if (PAR) apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_data", 32'(Data_OUT), 32'h0000_000b);

    // overrun: A commits, 5 dropped, then cleared
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(4'hA, 1'b1, 1'b0);
    send_word(4'h5, 1'b1, 1'b0);
    chk("t3_data", 32'(Data_OUT), 32'h0000_000a);
    chk("t3_ovr", 32'(Overrun), 1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_clr", 32'(Overrun), 0);

    // ready in the completing cycle replaces the held word
    send_word(4'h6, 1'b0, 1'b1);
    chk("t4_data", 32'(Data_OUT), 32'h0000_0006);
    chk("t4_valid", 32'(WordValid), 1);
    chk("t4_ovr", 32'(Overrun), 0);

    // asynchronous reset mid-word
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    SerialValid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clock);
    resetn = 1'b1;
    send_word(4'h3, 1'b1, 1'b0);
    chk("t5_data", 32'(Data_OUT), 32'h0000_0003);

`ifdef DESER_PARITY_EN
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_cnt4", 32'(BitCount), 4);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_perr0", 32'(ParityErr), 0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_perr1", 32'(ParityErr), 1);
`endif

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
